ps2_player_controls: RTL and testbench



---
 rtl/ps2_keys_pkg.sv | 63 ++++++
 rtl/ps2_player_controls_key_step_timer.sv | 42 ++++
 rtl/ps2_player_controls.sv | 147 ++++++++++++++
 tb/tb_ps2_player_controls.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// ============================================================================
// Module      : ps2_keys_pkg
// Description : Scan-code constants, prefix FSM states and key-mask helpers
//               shared by the PS/2 player-control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_keys_pkg;

  localparam logic [7:0] MAKE_W       = 8'h1D;
  localparam logic [7:0] MAKE_S       = 8'h1B;
  localparam logic [7:0] MAKE_A       = 8'h1C;
  localparam logic [7:0] MAKE_D       = 8'h23;
  localparam logic [7:0] ARROW_UP     = 8'h75;
  localparam logic [7:0] ARROW_DOWN   = 8'h72;
  localparam logic [7:0] ARROW_LEFT   = 8'h6B;
  localparam logic [7:0] ARROW_RIGHT  = 8'h74;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;

  // Bit positions inside every {W, S, A, D} held-key vector
  localparam int KEY_W = 3;
  localparam int KEY_S = 2;
  localparam int KEY_A = 1;
  localparam int KEY_D = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } prefix_state_t;

  function automatic logic [3:0] letter_mask(input logic [7:0] code);
    logic [3:0] m;
    m = '0;
    case (code)
      MAKE_W:  m[KEY_W] = 1'b1;
      MAKE_S:  m[KEY_S] = 1'b1;
      MAKE_A:  m[KEY_A] = 1'b1;
      MAKE_D:  m[KEY_D] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = '0;
    case (code)
      ARROW_UP:    m[KEY_W] = 1'b1;
      ARROW_DOWN:  m[KEY_S] = 1'b1;
      ARROW_LEFT:  m[KEY_A] = 1'b1;
      ARROW_RIGHT: m[KEY_D] = 1'b1;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_player_controls_key_step_timer.sv
// ============================================================================
// Module      : key_step_timer
// Description : Free-running step counter 0..TICK_CYCLES-1 with synchronous
//               restart; tick marks terminal count while running.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_step_timer #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int              CW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]   c_last = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == c_last);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (restart || !run || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  // A restart on the terminal cycle takes priority so no second pulse is issued
  assign tick = run & ~restart & w_last;

endmodule

`default_nettype wire

// File: rtl/ps2_player_controls.sv
// ============================================================================
// Module      : ps2_player_controls
// Description : PS/2 set-2 byte stream to held-key state and one-cycle
//               movement / rotation strobes. Optional arrow-key aliases are
//               enabled with the PS2_ARROW_KEYS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_player_controls
  import ps2_keys_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       forward,
  output logic       backward,
  output logic       rotateA,
  output logic       rotateD,
  output logic [3:0] keys_held
);

  prefix_state_t r_state, w_state_next;
  logic          w_make, w_break, w_ext;

  logic [3:0] r_hold, w_hold_next, w_letter;
  logic [3:0] w_alias_cur, w_alias_next;
  logic [3:0] w_merged_cur, w_merged_next, w_fresh;
  logic       w_fwd_ok, w_bwd_ok, w_move_fresh, w_run, w_tick;
  logic       w_forward, w_backward, w_rot_a, w_rot_d;

  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    w_ext        = 1'b0;
    if (scan_valid) begin
      case (r_state)
        IDLE: begin
          if (scan_code == PREFIX_BREAK)    w_state_next = BREAK;
          else if (scan_code == PREFIX_EXT) w_state_next = EXT;
          else                              w_make       = 1'b1;
        end
        BREAK: begin
          w_break      = 1'b1;
          w_state_next = IDLE;
        end
        EXT: begin
          if (scan_code == PREFIX_BREAK) begin
            w_state_next = EXT_BREAK;
          end else begin
            w_make       = 1'b1;
            w_ext        = 1'b1;
            w_state_next = IDLE;
          end
        end
        EXT_BREAK: begin
          w_break      = 1'b1;
          w_ext        = 1'b1;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_letter = letter_mask(scan_code);

  always_comb begin
    w_hold_next = r_hold;
    if (w_make && !w_ext)  w_hold_next = r_hold | w_letter;
    if (w_break && !w_ext) w_hold_next = r_hold & ~w_letter;
  end

`ifdef PS2_ARROW_KEYS_EN
  logic [3:0] r_alias, w_arrow;

  assign w_arrow = arrow_mask(scan_code);

  always_comb begin
    w_alias_next = r_alias;
    if (w_make && w_ext)  w_alias_next = r_alias | w_arrow;
    if (w_break && w_ext) w_alias_next = r_alias & ~w_arrow;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_alias <= '0;
    else         r_alias <= w_alias_next;
  end

  assign w_alias_cur = r_alias;
`else
  assign w_alias_cur  = '0;
  assign w_alias_next = '0;
`endif

  // A typematic repeat leaves the merged flag unchanged, so it is never fresh
  assign w_merged_cur  = r_hold | w_alias_cur;
  assign w_merged_next = w_hold_next | w_alias_next;
  assign w_fresh       = w_merged_next & ~w_merged_cur;

  assign w_fwd_ok     = w_merged_next[KEY_W] & ~w_merged_next[KEY_S];
  assign w_bwd_ok     = w_merged_next[KEY_S] & ~w_merged_next[KEY_W];
  assign w_move_fresh = w_fresh[KEY_W] | w_fresh[KEY_S];
  assign w_run        = w_merged_next[KEY_W] | w_merged_next[KEY_S];

  key_step_timer #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_step_timer (
    .clock   (clock),
    .resetn  (resetn),
    .restart (w_move_fresh),
    .run     (w_run),
    .tick    (w_tick)
  );

  assign w_forward  = (w_move_fresh | w_tick) & w_fwd_ok;
  assign w_backward = (w_move_fresh | w_tick) & w_bwd_ok;
  assign w_rot_a    = w_fresh[KEY_A] & ~w_merged_next[KEY_D];
  assign w_rot_d    = w_fresh[KEY_D] & ~w_merged_next[KEY_A];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      forward   <= 1'b0;
      backward  <= 1'b0;
      rotateA   <= 1'b0;
      rotateD   <= 1'b0;
      keys_held <= '0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      forward   <= w_forward;
      backward  <= w_backward;
      rotateA   <= w_rot_a;
      rotateD   <= w_rot_d;
      keys_held <= w_merged_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_player_controls.sv
// ============================================================================
// Module      : tb_ps2_player_controls
// Description : Scoreboard bench: directed scan-code vectors queue expected
//               strobes / held flags per clock edge; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_player_controls;

  localparam int T = 8;
  localparam logic [3:0] S_F  = 4'b1000;
  localparam logic [3:0] S_B  = 4'b0100;
  localparam logic [3:0] S_RA = 4'b0010;
  localparam logic [3:0] S_0  = 4'b0000;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       forward, backward, rotateA, rotateD;
  logic [3:0] keys_held;

  ps2_player_controls #(.TICK_CYCLES(T)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .forward    (forward),
    .backward   (backward),
    .rotateA    (rotateA),
    .rotateD    (rotateD),
    .keys_held  (keys_held)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_n;
    logic [3:0] val;
  } exp_t;

  exp_t sq[$];
  exp_t kq[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  task automatic push_s(input int e, input logic [3:0] v);
    int   i = 0;
    exp_t it;
    it.edge_n = e;
    it.val    = v;
    while (i < sq.size() && sq[i].edge_n <= e) i++;
    sq.insert(i, it);
  endtask

  task automatic push_k(input int e, input logic [3:0] v);
    int   i = 0;
    exp_t it;
    it.edge_n = e;
    it.val    = v;
    while (i < kq.size() && kq[i].edge_n <= e) i++;
    kq.insert(i, it);
  endtask

  // Monitor: strobes {fwd,bwd,rotA,rotD} and keys_held sampled at the falling edge
  always @(negedge clock) begin : mon
    logic [3:0] s;
    s = {forward, backward, rotateA, rotateD};
    if (sq.size() > 0 && sq[0].edge_n == edge_cnt) begin
      checks++;
      if (s !== sq[0].val) begin
        failures++;
        $display("FAIL strobes edge=%0d actual=%b required=%b", edge_cnt, s, sq[0].val);
      end
      void'(sq.pop_front());
    end else if (s != 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL unexpected_strobe edge=%0d actual=%b required=0000", edge_cnt, s);
    end
    if (kq.size() > 0 && kq[0].edge_n == edge_cnt) begin
      checks++;
      if (keys_held !== kq[0].val) begin
        failures++;
        $display("FAIL keys_held edge=%0d actual=%b required=%b", edge_cnt, keys_held, kq[0].val);
      end
      void'(kq.pop_front());
    end
    if (done) begin
      while (sq.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL missing_strobe edge=%0d actual=none required=%b", sq[0].edge_n, sq[0].val);
        void'(sq.pop_front());
      end
      while (kq.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL missing_keys edge=%0d actual=none required=%b", kq[0].edge_n, kq[0].val);
        void'(kq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Byte is sampled at the next rising edge; e returns that edge's index
  task automatic send(input logic [7:0] b, output int e);
    scan_code  = b;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    e = edge_cnt;
  endtask

  task automatic goto(input int k);
    while (edge_cnt < k - 1) tick();
  endtask

  initial begin
    int e, a, w, s, x;
    resetn = 1'b0;
    repeat (3) tick();
    push_s(edge_cnt + 1, S_0);
    push_k(edge_cnt + 1, 4'b0000);
    tick();
    resetn = 1'b1;
    tick();

    // W held alone: strobe at make, then every T; release stops repeats
    send(8'h1D, e);
    push_s(e, S_F);
    push_k(e, 4'b1000);
    push_s(e + T, S_F);
    push_s(e + 2 * T, S_F);
    goto(e + 2 * T + 2);
    send(8'hF0, x);
    send(8'h1D, x);
    push_k(x, 4'b0000);
    push_s(e + 3 * T, S_0);
    goto(e + 3 * T + 2);

    // Rotation: one pulse per press, typematic ignored, opposite key blocks
    send(8'h1C, a);
    push_s(a, S_RA);
    push_k(a, 4'b0010);
    send(8'h1C, x);
    push_s(x, S_0);
    send(8'h1C, x);
    push_s(x, S_0);
    send(8'h23, x);
    push_s(x, S_0);
    push_k(x, 4'b0011);
    send(8'hF0, x);
    send(8'h1C, x);
    send(8'hF0, x);
    send(8'h23, x);
    push_k(x, 4'b0000);
    tick();

    // W then S made at W's terminal count; S alone repeats after W release
    send(8'h1D, w);
    push_s(w, S_F);
    goto(w + T);
    send(8'h1B, s);
    push_s(s, S_0);
    push_k(s, 4'b1100);
    push_s(s + T, S_0);
    goto(s + 10);
    send(8'hF0, x);
    send(8'h1D, x);
    push_k(x, 4'b0100);
    push_s(s + 2 * T, S_B);
    push_s(s + 3 * T, S_B);
    goto(s + 3 * T + 1);
    send(8'hF0, x);
    send(8'h1B, x);
    push_k(x, 4'b0000);
    push_s(s + 4 * T, S_0);
    goto(s + 4 * T + 2);

    // Release landing on the terminal edge suppresses that repeat
    send(8'h1D, w);
    push_s(w, S_F);
    push_s(w + T, S_F);
    goto(w + 2 * T - 1);
    send(8'hF0, x);
    send(8'h1D, x);
    push_s(x, S_0);
    push_k(x, 4'b0000);
    tick();

    // Reset after a break prefix discards it
    send(8'hF0, x);
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    send(8'h1D, x);
    push_s(x, S_F);
    push_k(x, 4'b1000);
    send(8'hF0, x);
    send(8'h1D, x);
    push_k(x, 4'b0000);
    tick();

    // Extended codes: arrow alias (when enabled) and E0 1D never acts as W
    send(8'hE0, x);
    send(8'h75, x);
`ifdef PS2_ARROW_KEYS_EN
    push_s(x, S_F);
    push_k(x, 4'b1000);
`else
    push_s(x, S_0);
    push_k(x, 4'b0000);
`endif
    send(8'hE0, x);
    send(8'hF0, x);
    send(8'h75, x);
    push_s(x, S_0);
    push_k(x, 4'b0000);
    send(8'hE0, x);
    send(8'h1D, x);
    push_s(x, S_0);
    push_k(x, 4'b0000);
    tick();

    // Unmapped code back-to-back with a W make
    send(8'h2B, x);
    push_s(x, S_0);
    send(8'hF0, x);
    send(8'h2B, x);
    push_k(x, 4'b0000);
    send(8'h1D, x);
    push_s(x, S_F);
    push_k(x, 4'b1000);
    send(8'hF0, x);
    send(8'h1D, x);
    push_k(x, 4'b0000);

    repeat (T + 4) tick();
    done = 1'b1;
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
